// File: rtl/jtopl_pkg.sv
// rtl/jtopl_pkg.sv - shared JTOPL timer-bank constants and helpers
package jtopl_pkg;

    localparam int JTOPL_TIMER_NT       = 2;
    localparam int JTOPL_TIMER_W        = 8;
    localparam int JTOPL_TIMER_PRE_LOG2 = 2;

    // Prescaler is just wide enough to produce the slowest timer's tick
    function automatic int pre_width(input int nt, input int pre_log2);
        return nt * pre_log2;
    endfunction

endpackage

// File: rtl/jtopl_timer_bank_if.sv
// rtl/jtopl_timer_bank_if.sv - register-side bundle between jtopl_mmr and the timer bank
interface jtopl_timer_bank_if
    import jtopl_pkg::*;
#(
    parameter int NT = JTOPL_TIMER_NT,
    parameter int W  = JTOPL_TIMER_W
);
    logic [NT*W-1:0] value;
    logic [NT-1:0]   load;
    logic [NT-1:0]   flagen;
    logic            clr_flags;
    logic [NT-1:0]   flag;
    logic [NT-1:0]   overflow;
    logic            irq_n;

    modport master (
        output value, load, flagen, clr_flags,
        input  flag, overflow, irq_n
    );

    modport slave (
        input  value, load, flagen, clr_flags,
        output flag, overflow, irq_n
    );
endinterface

// File: rtl/jtopl_timer_cnt.sv
// rtl/jtopl_timer_cnt.sv - one up-counting timer with load edge detect, sticky flag and overflow strobe
module jtopl_timer_cnt
    import jtopl_pkg::*;
#(
    parameter int W = JTOPL_TIMER_W
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         cenop,
    input  logic         tick,
    input  logic         load,
    input  logic         flagen,
    input  logic         clr_flags,
    input  logic [W-1:0] value,
    output logic         flag,
    output logic         overflow
);

    logic [W-1:0] cnt;
    logic         load_l;
    logic         load_rise;
    logic         ovf_set;

    assign load_rise = load & ~load_l;
    // A tick coinciding with the load edge is swallowed by the reload
    assign ovf_set   = load & load_l & tick & (&cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            load_l   <= 1'b0;
            flag     <= 1'b0;
            overflow <= 1'b0;
        end else if (cenop) begin
            load_l   <= load;
            overflow <= ovf_set;
            if (load_rise) begin
                cnt <= value;
            end else if (load && tick) begin
                cnt <= (&cnt) ? value : cnt + W'(1);
            end
            // Set has priority so an overflow racing an IRQ reset is kept
            if (ovf_set && flagen) begin
                flag <= 1'b1;
            end else if (clr_flags || !flagen) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtopl_timer_bank.sv
// rtl/jtopl_timer_bank.sv - NT-timer bank with prescaler and IRQ; CSM key-on under JTOPL_CSM_EN
module jtopl_timer_bank
    import jtopl_pkg::*;
#(
    parameter int NT       = JTOPL_TIMER_NT,
    parameter int W        = JTOPL_TIMER_W,
    parameter int PRE_LOG2 = JTOPL_TIMER_PRE_LOG2
) (
    input  logic rst,
    input  logic clk,
    input  logic cenop,
    input  logic zero,
`ifdef JTOPL_CSM_EN
    input  logic csm,
    output logic csm_keyon,
`endif
    jtopl_timer_bank_if.slave bus
);

    localparam int PW = pre_width(NT, PRE_LOG2);

    logic [PW-1:0] pre;
    logic [NT-1:0] tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (cenop && zero) begin
            pre <= pre + PW'(1);
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_timer
        // Timer i sees one tick per 2^(PRE_LOG2*(i+1)) zero pulses
        assign tick[i] = cenop & zero & (&pre[PRE_LOG2*(i+1)-1:0]);

        jtopl_timer_cnt #(.W(W)) u_cnt (
            .rst       (rst),
            .clk       (clk),
            .cenop     (cenop),
            .tick      (tick[i]),
            .load      (bus.load[i]),
            .flagen    (bus.flagen[i]),
            .clr_flags (bus.clr_flags),
            .value     (bus.value[i*W +: W]),
            .flag      (bus.flag[i]),
            .overflow  (bus.overflow[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.irq_n <= 1'b1;
        end else if (cenop) begin
            bus.irq_n <= ~|bus.flag;
        end
    end

`ifdef JTOPL_CSM_EN
    // csm captured alongside the overflow register so the key-on pairs with overflow[0]
    logic csm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csm_q <= 1'b0;
        end else if (cenop) begin
            csm_q <= csm;
        end
    end

    assign csm_keyon = csm_q & bus.overflow[0];
`endif

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// tb/tb_jtopl_timer_bank.sv - self-checking bench for jtopl_timer_bank
module tb_jtopl_timer_bank;
    import jtopl_pkg::*;

    localparam int NT  = 2;
    localparam int W   = 8;
    localparam int PL  = 2;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic cenop;
    logic zero;
    logic csm;
`ifdef JTOPL_CSM_EN
    logic csm_keyon;
`endif

    jtopl_timer_bank_if #(.NT(NT), .W(W)) bus ();

    jtopl_timer_bank #(.NT(NT), .W(W), .PRE_LOG2(PL)) dut (
        .rst   (rst),
        .clk   (clk),
        .cenop (cenop),
        .zero  (zero),
`ifdef JTOPL_CSM_EN
        .csm       (csm),
        .csm_keyon (csm_keyon),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: counters as integers, prescaler as a running count of zero pulses
    int          m_cnt [NT];
    bit [NT-1:0] m_ll;
    bit [NT-1:0] m_flag;
    bit [NT-1:0] m_ovf;
    bit          m_irq_n;
    bit          m_keyon;
    int          m_npz;

    int pc, n0, n1, nk, first0, first1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) m_cnt[i] = 0;
        m_ll = '0; m_flag = '0; m_ovf = '0;
        m_irq_n = 1'b1; m_keyon = 1'b0; m_npz = 0;
    endfunction

    function automatic void model_step();
        bit [NT-1:0] ev;
        bit [NT-1:0] nflag;
        bit          tk;
        int          rv;
        if (rst) begin
            model_reset();
            return;
        end
        if (!cenop) return;
        ev = '0;
        nflag = m_flag;
        for (int i = 0; i < NT; i++) begin
            tk = zero && (((m_npz + 1) % (1 << (PL * (i + 1)))) == 0);
            rv = int'(bus.value[i*W +: W]);
            if (bus.load[i] && !m_ll[i]) begin
                m_cnt[i] = rv;
            end else if (bus.load[i] && tk) begin
                if (m_cnt[i] == MAX) begin
                    m_cnt[i] = rv;
                    ev[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_ll[i] = bus.load[i];
            if (ev[i] && bus.flagen[i]) nflag[i] = 1'b1;
            else if (bus.clr_flags || !bus.flagen[i]) nflag[i] = 1'b0;
        end
        if (zero) m_npz++;
        m_irq_n = (m_flag == '0);
        m_flag  = nflag;
        m_ovf   = ev;
        m_keyon = csm && ev[0];
    endfunction

    task automatic step(input bit c, input bit z);
        cenop = c;
        zero  = z;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("flag", 32'(bus.flag), 32'(m_flag));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("irq_n", 32'(bus.irq_n), 32'(m_irq_n));
`ifdef JTOPL_CSM_EN
        chk("csm_keyon", 32'(csm_keyon), 32'(m_keyon));
`endif
    endtask

    task automatic zpulse(input bit clr);
        bus.clr_flags = clr;
        step(1'b1, 1'b1);
        bus.clr_flags = 1'b0;
        pc++;
        if (bus.overflow[0]) begin n0++; if (first0 == 0) first0 = pc; end
        if (bus.overflow[1]) begin n1++; if (first1 == 0) first1 = pc; end
`ifdef JTOPL_CSM_EN
        if (csm_keyon) nk++;
`endif
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic run(input int n);
        pc = 0; n0 = 0; n1 = 0; nk = 0; first0 = 0; first1 = 0;
        for (int k = 0; k < n; k++) zpulse(1'b0);
    endtask

    initial begin
        rst = 1'b1; cenop = 1'b0; zero = 1'b0; csm = 1'b1;
        bus.value = '0; bus.load = '0; bus.flagen = '0; bus.clr_flags = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_flag", 32'(bus.flag), 32'h0);
        chk("reset_overflow", 32'(bus.overflow), 32'h0);
        chk("reset_irq_n", 32'(bus.irq_n), 32'h1);
        rst = 1'b0;
        step(1'b1, 1'b0);

        // Timer 0 from FE (period 8) alongside timer 1 from FF (period 16)
        bus.value = {8'hFF, 8'hFE};
        bus.flagen = 2'b11;
        bus.load = 2'b11;
        step(1'b1, 1'b0);
        run(32);
        chk("t0_first", 32'(first0), 32'd8);
        chk("t0_count", 32'(n0), 32'd4);
        chk("t1_first", 32'(first1), 32'd16);
        chk("t1_count", 32'(n1), 32'd2);
        chk("t01_flag", 32'(bus.flag), 32'h3);
        chk("t01_irq_n", 32'(bus.irq_n), 32'h0);
`ifdef JTOPL_CSM_EN
        chk("csm_count", 32'(nk), 32'(n0));
`endif

        // clr_flags lands on the timer-0 overflow at pulse 40
        run(7);
        zpulse(1'b1);
        chk("collide_flag", 32'(bus.flag), 32'h1);
        bus.clr_flags = 1'b1;
        step(1'b1, 1'b0);
        bus.clr_flags = 1'b0;
        chk("clr_flag", 32'(bus.flag), 32'h0);
        step(1'b1, 1'b0);
        chk("clr_irq_n", 32'(bus.irq_n), 32'h1);

        // Masked timer 0 from FF: overflow every 4 pulses, no flag
        bus.load = 2'b00;
        bus.flagen = 2'b10;
        step(1'b1, 1'b0);
        bus.value[7:0] = 8'hFF;
        bus.load = 2'b01;
        step(1'b1, 1'b0);
        run(12);
        chk("mask_first", 32'(first0), 32'd4);
        chk("mask_count", 32'(n0), 32'd3);
        chk("mask_flag", 32'(bus.flag), 32'h0);
        chk("mask_irq_n", 32'(bus.irq_n), 32'h1);

        // Stop at 80 must freeze; restart from 10 gives (256-16)*4 pulses
        bus.value[7:0] = 8'h80;
        bus.load = 2'b00;
        step(1'b1, 1'b0);
        bus.load = 2'b01;
        step(1'b1, 1'b0);
        bus.load = 2'b00;
        step(1'b1, 1'b0);
        run(20);
        chk("stop_count", 32'(n0), 32'd0);
        bus.value[7:0] = 8'h10;
        bus.flagen = 2'b01;
        bus.load = 2'b01;
        step(1'b1, 1'b0);
        run(960);
        chk("restart_first", 32'(first0), 32'd960);
        chk("restart_count", 32'(n0), 32'd1);
        chk("restart_flag", 32'(bus.flag), 32'h1);

        // Reset mid-count, then count again from a fresh prescaler
        run(3);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_flag", 32'(bus.flag), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        chk("rst_irq_n", 32'(bus.irq_n), 32'h1);
`ifdef JTOPL_CSM_EN
        chk("rst_csm_keyon", 32'(csm_keyon), 32'h0);
`endif
        bus.value[7:0] = 8'hFE;
        step(1'b1, 1'b1);
        rst = 1'b0;
        step(1'b1, 1'b0);
        run(8);
        chk("post_rst_first", 32'(first0), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
